nn_layer_sequencer: RTL and testbench

// Moore controller that time-multiplexes one shared MAC datapath across all

---
 rtl/nn_layer_sequencer_pkg.sv | 24 ++
 rtl/nn_layer_sequencer_if.sv | 38 +++
 rtl/nn_layer_sequencer_counter.sv | 38 +++
 rtl/nn_layer_sequencer.sv | 141 ++++++++++++++
 tb/tb_nn_layer_sequencer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_layer_sequencer_pkg.sv
// rtl/nn_layer_sequencer_pkg.sv - shared types, defaults and width helper for the layer sequencer
package nn_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      CLEAR = 3'd2,
      ACCUM = 3'd3,
      DRAIN = 3'd4,
      WRITE = 3'd5,
      DONE  = 3'd6
   } seq_state_t;

   localparam int N_IN_DEF     = 4;
   localparam int N_NEUR_DEF   = 4;
   localparam int N_LAYERS_DEF = 3;
   localparam int MAC_LAT_DEF  = 2;

   // Index width that never collapses to zero bits for tiny sizes
   function automatic int safe_clog2(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/nn_layer_sequencer_if.sv
// rtl/nn_layer_sequencer_if.sv - sample/result handshake and MAC control bundle
interface nn_layer_sequencer_if
   import nn_pkg::*;
#(
   parameter int N_IN     = N_IN_DEF,
   parameter int N_NEUR   = N_NEUR_DEF,
   parameter int N_LAYERS = N_LAYERS_DEF
);
   localparam int AW = safe_clog2(N_LAYERS * N_NEUR * N_IN);
   localparam int XW = safe_clog2(N_IN);
   localparam int NW = safe_clog2(N_NEUR);

   logic                in_valid;
   logic                in_ready;
   logic                out_valid;
   logic                out_ready;
   logic                load_en;
   logic [AW-1:0]       w_addr;
   logic [XW-1:0]       x_sel;
   logic                mac_clr;
   logic                mac_en;
   logic [N_LAYERS-1:0] layer_en;
   logic [NW-1:0]       neur_idx;
   logic                busy;

   modport master (
      input  in_valid, out_ready,
      output in_ready, out_valid, load_en, w_addr, x_sel, mac_clr, mac_en,
             layer_en, neur_idx, busy
   );

   modport slave (
      output in_valid, out_ready,
      input  in_ready, out_valid, load_en, w_addr, x_sel, mac_clr, mac_en,
             layer_en, neur_idx, busy
   );

endinterface

// File: rtl/nn_layer_sequencer_counter.sv
// rtl/nn_layer_sequencer_counter.sv - modulo counter that wraps to zero on its terminal value
module nn_wrap_counter #(
   parameter int WIDTH = 1,
   parameter int MAX   = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] cnt_o,
   output logic             last_o
);
   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   assign last_o = (cnt_q == WIDTH'(MAX));
   assign cnt_o  = cnt_q;

   // Clear wins over increment; increment on the terminal value wraps to zero
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = last_o ? '0 : cnt_q + 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/nn_layer_sequencer.sv
// rtl/nn_layer_sequencer.sv - Moore sequencer sharing one MAC across all neurons of all layers
module nn_layer_sequencer
   import nn_pkg::*;
#(
   parameter int N_IN     = N_IN_DEF,
   parameter int N_NEUR   = N_NEUR_DEF,
   parameter int N_LAYERS = N_LAYERS_DEF,
   parameter int MAC_LAT  = MAC_LAT_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   nn_layer_sequencer_if.master bus
);
   localparam int IW   = safe_clog2(N_IN);
   localparam int NW   = safe_clog2(N_NEUR);
   localparam int LW   = safe_clog2(N_LAYERS);
   localparam int DW   = safe_clog2(MAC_LAT);
   localparam int AW   = safe_clog2(N_LAYERS * N_NEUR * N_IN);
   localparam int DMAX = (MAC_LAT > 0) ? MAC_LAT - 1 : 0;

   seq_state_t state_q;
   seq_state_t state_d;

   logic [IW-1:0] i_cnt;
   logic [NW-1:0] n_cnt;
   logic [LW-1:0] l_cnt;
   logic [DW-1:0] d_cnt;
   logic          i_last, n_last, l_last, d_last;
   logic          i_inc, i_clr, n_inc, l_inc, d_inc, cnt_clr;
   logic          d_unused;

   logic                in_ready, out_valid, load_en, mac_clr, mac_en, busy;
   logic [AW-1:0]       w_addr;
   logic [IW-1:0]       x_sel;
   logic [N_LAYERS-1:0] layer_en;
   logic [NW-1:0]       neur_idx;

   // The drain length is all that matters; its count value is not decoded
   assign d_unused = ^d_cnt;

   nn_wrap_counter #(.WIDTH(IW), .MAX(N_IN - 1)) u_i_cnt (
      .clk(clk), .reset(reset), .inc_i(i_inc), .clr_i(i_clr | cnt_clr),
      .cnt_o(i_cnt), .last_o(i_last));

   nn_wrap_counter #(.WIDTH(NW), .MAX(N_NEUR - 1)) u_n_cnt (
      .clk(clk), .reset(reset), .inc_i(n_inc), .clr_i(cnt_clr),
      .cnt_o(n_cnt), .last_o(n_last));

   nn_wrap_counter #(.WIDTH(LW), .MAX(N_LAYERS - 1)) u_l_cnt (
      .clk(clk), .reset(reset), .inc_i(l_inc), .clr_i(cnt_clr),
      .cnt_o(l_cnt), .last_o(l_last));

   nn_wrap_counter #(.WIDTH(DW), .MAX(DMAX)) u_d_cnt (
      .clk(clk), .reset(reset), .inc_i(d_inc), .clr_i(cnt_clr),
      .cnt_o(d_cnt), .last_o(d_last));

   // State register; reset aborts a pass in flight before any further bank write
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and Moore output decode from state and counters only
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      load_en   = 1'b0;
      mac_clr   = 1'b0;
      mac_en    = 1'b0;
      busy      = 1'b1;
      w_addr    = '0;
      x_sel     = '0;
      layer_en  = '0;
      neur_idx  = '0;
      i_inc     = 1'b0;
      i_clr     = 1'b0;
      n_inc     = 1'b0;
      l_inc     = 1'b0;
      d_inc     = 1'b0;
      cnt_clr   = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            cnt_clr  = 1'b1;
            if (bus.in_valid) state_d = LOAD;
         end
         LOAD: begin
            load_en = 1'b1;
            state_d = CLEAR;
         end
         CLEAR: begin
            mac_clr = 1'b1;
            i_clr   = 1'b1;
            state_d = ACCUM;
         end
         ACCUM: begin
            mac_en = 1'b1;
            x_sel  = i_cnt;
            w_addr = AW'((int'(l_cnt) * N_NEUR + int'(n_cnt)) * N_IN + int'(i_cnt));
            i_inc  = 1'b1;
            if (i_last) state_d = (MAC_LAT == 0) ? WRITE : DRAIN;
         end
         DRAIN: begin
            d_inc = 1'b1;
            if (d_last) state_d = WRITE;
         end
         WRITE: begin
            layer_en = N_LAYERS'(1) << l_cnt;
            neur_idx = n_cnt;
            n_inc    = 1'b1;
            l_inc    = n_last;
            state_d  = (n_last && l_last) ? DONE : CLEAR;
         end
         DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: begin
            cnt_clr = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.load_en   = load_en;
   assign bus.mac_clr   = mac_clr;
   assign bus.mac_en    = mac_en;
   assign bus.busy      = busy;
   assign bus.w_addr    = w_addr;
   assign bus.x_sel     = x_sel;
   assign bus.layer_en  = layer_en;
   assign bus.neur_idx  = neur_idx;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb/tb_nn_layer_sequencer.sv - scoreboard bench for the default and a small no-drain sequencer
module tb_nn_layer_sequencer;
   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   // Cycle index used for latency and gap measurement
   always @(posedge clk) cyc <= cyc + 1;

   nn_layer_sequencer_if #(.N_IN(4), .N_NEUR(4), .N_LAYERS(3)) bus_a ();
   nn_layer_sequencer_if #(.N_IN(1), .N_NEUR(3), .N_LAYERS(3)) bus_b ();

   nn_layer_sequencer #(.N_IN(4), .N_NEUR(4), .N_LAYERS(3), .MAC_LAT(2)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a));
   nn_layer_sequencer #(.N_IN(1), .N_NEUR(3), .N_LAYERS(3), .MAC_LAT(0)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b));

   typedef struct packed {
      logic       ir, ov, ld, clr, en, busy;
      logic [7:0] addr, xs, le, ni;
   } snap_t;

   int addr_q[2][$];
   int wr_q[2][$];
   int gap_q[2][$];
   int pass_q[2][$];
   int nin[2]     = '{4, 1};
   int nneur[2]   = '{4, 3};
   bit mon_en[2]  = '{1'b0, 1'b0};
   bit prev_ov[2] = '{1'b0, 1'b0};
   int load_cyc[2], hs_cyc[2], clr_cnt[2], en_cnt[2], load_cnt[2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   function automatic snap_t snap(input int u);
      snap_t s;
      if (u == 0) begin
         s = '{bus_a.in_ready, bus_a.out_valid, bus_a.load_en, bus_a.mac_clr, bus_a.mac_en,
               bus_a.busy, 8'(bus_a.w_addr), 8'(bus_a.x_sel), 8'(bus_a.layer_en), 8'(bus_a.neur_idx)};
      end else begin
         s = '{bus_b.in_ready, bus_b.out_valid, bus_b.load_en, bus_b.mac_clr, bus_b.mac_en,
               bus_b.busy, 8'(bus_b.w_addr), 8'(bus_b.x_sel), 8'(bus_b.layer_en), 8'(bus_b.neur_idx)};
      end
      return s;
   endfunction

   task automatic set_in(input int u, input logic v);
      if (u == 0) bus_a.in_valid = v; else bus_b.in_valid = v;
   endtask

   task automatic set_ordy(input int u, input logic v);
      if (u == 0) bus_a.out_ready = v; else bus_b.out_ready = v;
   endtask

   task automatic check_idle(input int u, input string tag);
      snap_t s = snap(u);
      check({tag, " in_ready"}, 32'(s.ir), 1);
      check({tag, " busy"}, 32'(s.busy), 0);
      check({tag, " out_valid"}, 32'(s.ov), 0);
      check({tag, " load_en"}, 32'(s.ld), 0);
      check({tag, " mac_clr"}, 32'(s.clr), 0);
      check({tag, " mac_en"}, 32'(s.en), 0);
      check({tag, " layer_en"}, 32'(s.le), 0);
      check({tag, " w_addr"}, 32'(s.addr), 0);
      check({tag, " x_sel"}, 32'(s.xs), 0);
      check({tag, " neur_idx"}, 32'(s.ni), 0);
   endtask

   // Expected addresses run 0..total-1, writes walk L0n0 upward, then pass totals
   task automatic push_pass(input int u, input int lat);
      int total = 3 * nneur[u] * nin[u];
      for (int a = 0; a < total; a++) addr_q[u].push_back(a);
      for (int l = 0; l < 3; l++)
         for (int n = 0; n < nneur[u]; n++) wr_q[u].push_back(((1 << l) << 8) | n);
      pass_q[u].push_back(lat);
      pass_q[u].push_back(3 * nneur[u]);
      pass_q[u].push_back(total);
   endtask

   task automatic observe(input int u, input snap_t s, input logic ordy);
      int e;
      if (!mon_en[u]) return;
      if (s.en) begin
         en_cnt[u]++;
         check($sformatf("u%0d mac_en overlap", u), 32'(s.clr | (s.le != 0)), 0);
         if (addr_q[u].size() == 0) fail_now($sformatf("u%0d unexpected mac_en", u));
         else begin
            e = addr_q[u].pop_front();
            check($sformatf("u%0d w_addr", u), 32'(s.addr), e);
            check($sformatf("u%0d x_sel", u), 32'(s.xs), e % nin[u]);
         end
      end
      if (s.clr) clr_cnt[u]++;
      if (s.le != 0) begin
         if (wr_q[u].size() == 0) fail_now($sformatf("u%0d unexpected layer_en", u));
         else begin
            e = wr_q[u].pop_front();
            check($sformatf("u%0d layer_en", u), 32'(s.le), e >> 8);
            check($sformatf("u%0d neur_idx", u), 32'(s.ni), e & 255);
         end
      end
      if (s.ld) begin
         load_cnt[u]++;
         if (gap_q[u].size() != 0) check($sformatf("u%0d handshake-to-load gap", u), cyc - hs_cyc[u], gap_q[u].pop_front());
         load_cyc[u] = cyc;
         clr_cnt[u]  = 0;
         en_cnt[u]   = 0;
      end
      if (s.ov && !prev_ov[u]) begin
         if (pass_q[u].size() < 3) fail_now($sformatf("u%0d unexpected out_valid", u));
         else begin
            check($sformatf("u%0d out_valid latency", u), cyc - load_cyc[u] + 1, pass_q[u].pop_front());
            check($sformatf("u%0d mac_clr pulses", u), clr_cnt[u], pass_q[u].pop_front());
            check($sformatf("u%0d mac_en cycles", u), en_cnt[u], pass_q[u].pop_front());
            check($sformatf("u%0d load pulses", u), load_cnt[u], 1);
         end
         load_cnt[u] = 0;
      end
      if (s.ov && ordy) hs_cyc[u] = cyc;
      prev_ov[u] = s.ov;
   endtask

   // Monitor samples on the falling edge, away from state updates
   always @(negedge clk) begin
      observe(0, snap(0), bus_a.out_ready);
      observe(1, snap(1), bus_b.out_ready);
   end

   task automatic wait_out(input int u, input string tag);
      snap_t s;
      for (int k = 0; k < 300; k++) begin
         @(posedge clk); #2;
         s = snap(u);
         if (s.ov) return;
      end
      fail_now({tag, " out_valid timeout"});
   endtask

   task automatic start(input int u);
      @(posedge clk); #2;
      set_in(u, 1'b1);
      @(posedge clk); #2;
      set_in(u, 1'b0);
   endtask

   task automatic run_pass(input int u, input int lat, input string tag);
      snap_t s;
      push_pass(u, lat);
      set_ordy(u, 1'b1);
      start(u);
      wait_out(u, tag);
      @(posedge clk); #2;
      s = snap(u);
      check({tag, " in_ready after handshake"}, 32'(s.ir), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      snap_t s;
      bit    found;
      set_in(0, 1'b0); set_in(1, 1'b0);
      set_ordy(0, 1'b0); set_ordy(1, 1'b0);
      repeat (2) @(posedge clk);
      #2;
      check_idle(0, "reset a");
      check_idle(1, "reset b");
      reset  = 1'b0;
      mon_en = '{1'b1, 1'b1};

      run_pass(0, 98, "nominal");

      push_pass(0, 98);
      set_ordy(0, 1'b0);
      start(0);
      wait_out(0, "backpressure");
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #2;
         s = snap(0);
         check("backpressure out_valid held", 32'(s.ov), 1);
         check("backpressure in_ready low", 32'(s.ir), 0);
      end
      set_ordy(0, 1'b1);
      @(posedge clk); #2;
      s = snap(0);
      check("backpressure in_ready after release", 32'(s.ir), 1);

      push_pass(0, 98);
      push_pass(0, 98);
      @(posedge clk); #2;
      set_in(0, 1'b1);
      wait_out(0, "busy first");
      gap_q[0].push_back(2);
      @(posedge clk); #2;
      s = snap(0);
      check("busy in_ready after handshake", 32'(s.ir), 1);
      @(posedge clk); #2;
      s = snap(0);
      check("busy second load_en", 32'(s.ld), 1);
      set_in(0, 1'b0);
      wait_out(0, "busy second");
      @(posedge clk); #2;

      push_pass(0, 98);
      start(0);
      found = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(posedge clk); #2;
         s = snap(0);
         if (s.en && s.addr == 8'd20) begin
            found = 1'b1;
            break;
         end
      end
      check("reached layer 1 accumulate", 32'(found), 1);
      mon_en[0] = 1'b0;
      reset = 1'b1;
      #1;
      check_idle(0, "mid-run reset");
      addr_q[0].delete(); wr_q[0].delete(); pass_q[0].delete(); gap_q[0].delete();
      prev_ov[0] = 1'b0; load_cnt[0] = 0; clr_cnt[0] = 0; en_cnt[0] = 0;
      @(posedge clk); #2;
      reset = 1'b0;
      mon_en[0] = 1'b1;
      run_pass(0, 98, "after reset");

      run_pass(1, 29, "small");

      repeat (3) @(posedge clk);
      #2;
      for (int u = 0; u < 2; u++) begin
         check($sformatf("u%0d addresses left", u), addr_q[u].size(), 0);
         check($sformatf("u%0d writes left", u), wr_q[u].size(), 0);
         check($sformatf("u%0d passes left", u), pass_q[u].size(), 0);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
